// File: rtl/counter_pkg.sv
// Shared widths and the packed layout of the frequency-meter output word.
package counter_pkg;
  localparam int CNT_W   = 8;
  localparam int DELTA_W = 4;
  localparam int WRAP_W  = 24;
  localparam int PER_W   = 16;

  typedef struct packed {
    logic [WRAP_W-1:0] wrap_count;
    logic [PER_W-1:0]  period;
  } freq_t;
endpackage

// File: rtl/wrap_meter.sv
// Counts wrap events and measures the cycle distance between the last two wraps.
module wrap_meter
  import counter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wrap,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [PER_W-1:0]  period
);

  logic [PER_W-1:0] cyc_cnt;
  logic [PER_W-1:0] cyc_inc;

  // Saturating increment shared by the running counter and the latched period.
  assign cyc_inc = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + PER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt    <= '0;
      period     <= '0;
      wrap_count <= '0;
    end else if (clear) begin
      cyc_cnt <= '0;
    end else if (wrap) begin
      period  <= cyc_inc;
      cyc_cnt <= '0;
      if (wrap_count != '1)
        wrap_count <= wrap_count + WRAP_W'(1);
    end else begin
      cyc_cnt <= cyc_inc;
    end
  end

endmodule

// File: rtl/counter.sv
// 8-bit up/down step counter with preload; wrap carry/borrow feeds the frequency meter.
module counter
  import counter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               preload,
  input  logic               up_dn,
  input  logic [DELTA_W-1:0] delta,
  input  logic [CNT_W-1:0]   pl_data,
  output logic [CNT_W-1:0]   qout,
  output logic [$bits(freq_t)-1:0] freq_out
);

  logic [CNT_W:0] sum_up;
  logic [CNT_W:0] diff_dn;
  logic           wrap;
  freq_t          freq;

  // Ninth bit of the extended sum is the carry; of the difference, the borrow.
  assign sum_up  = {1'b0, qout} + (CNT_W+1)'(delta);
  assign diff_dn = {1'b0, qout} - (CNT_W+1)'(delta);
  assign wrap    = up_dn ? sum_up[CNT_W] : diff_dn[CNT_W];

  always_ff @(posedge clk) begin
    if (reset)
      qout <= '0;
    else if (preload)
      qout <= pl_data;
    else if (up_dn)
      qout <= sum_up[CNT_W-1:0];
    else
      qout <= diff_dn[CNT_W-1:0];
  end

  wrap_meter u_wrap_meter (
    .clk        (clk),
    .reset      (reset),
    .clear      (preload),
    .wrap       (wrap),
    .wrap_count (freq.wrap_count),
    .period     (freq.period)
  );

  assign freq_out = freq;

endmodule

// File: tb/tb_counter.sv
// Directed scoreboard bench for counter: driver queues expectations, monitor checks at negedge.
module tb_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b0;
  logic        up_dn = 1'b1;
  logic [3:0]  delta = 4'd0;
  logic [7:0]  pl_data = 8'd0;
  logic [7:0]  qout;
  logic [39:0] freq_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    int          cyc;
    logic [7:0]  q;
    logic [23:0] w;
    logic [15:0] p;
    bit          cq;
    bit          cw;
    bit          cp;
  } exp_t;

  exp_t sb[$];

  counter dut (
    .clk      (clk),
    .reset    (reset),
    .preload  (preload),
    .up_dn    (up_dn),
    .delta    (delta),
    .pl_data  (pl_data),
    .qout     (qout),
    .freq_out (freq_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input logic [7:0] q, input logic [23:0] w,
                            input logic [15:0] p, input bit cq, input bit cw, input bit cp);
    exp_t e;
    e.name = name; e.cyc = cyc; e.q = q; e.w = w; e.p = p;
    e.cq = cq; e.cw = cw; e.cp = cp;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input string fld, input logic [23:0] act,
                     input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", name, fld, act, exp);
    end
  endtask

  // Monitor: retire every expectation due at this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else begin
        if (e.cq) cmp(e.name, "qout", {16'd0, qout}, {16'd0, e.q});
        if (e.cw) cmp(e.name, "wrap_count", freq_out[39:16], e.w);
        if (e.cp) cmp(e.name, "period", {8'd0, freq_out[15:0]}, {8'd0, e.p});
      end
    end
  end

  initial begin
    tick(3);
    expect_now("reset", 8'd0, 24'd0, 16'd0, 1, 1, 1);

    reset = 1'b0; up_dn = 1'b1; delta = 4'd6;
    tick(1);  expect_now("up_first",    8'd6,   24'd0, 16'd0,  1, 1, 1);
    tick(41); expect_now("up_prewrap",  8'd252, 24'd0, 16'd0,  1, 1, 1);
    tick(1);  expect_now("wrap1",       8'd2,   24'd1, 16'd43, 1, 1, 1);
    tick(43); expect_now("wrap2",       8'd4,   24'd2, 16'd43, 1, 1, 1);
    tick(42); expect_now("wrap3",       8'd0,   24'd3, 16'd42, 1, 1, 1);
    tick(2872); expect_now("run3000",   8'd80,  24'd70, 16'd0, 1, 1, 0);

    preload = 1'b1; pl_data = 8'h05;
    tick(1);  expect_now("preload5",    8'h05,  24'd70, 16'd0, 1, 1, 0);
    preload = 1'b0; up_dn = 1'b0; delta = 4'd7;
    tick(1);  expect_now("down_wrap",   8'hFE,  24'd71, 16'd1, 1, 1, 1);

    delta = 4'd0;
    tick(100); expect_now("hold100",    8'hFE,  24'd71, 16'd1, 1, 1, 1);

    up_dn = 1'b1; delta = 4'd3; preload = 1'b1; pl_data = 8'h33;
    tick(1);  expect_now("preload_beats_wrap", 8'h33, 24'd71, 16'd1, 1, 1, 1);

    pl_data = 8'd7;
    tick(1);  expect_now("preload7",    8'd7,   24'd71, 16'd1, 1, 1, 1);
    preload = 1'b0; up_dn = 1'b0; delta = 4'd7;
    tick(1);  expect_now("down_eq_nowrap", 8'd0, 24'd71, 16'd1, 1, 1, 1);
    tick(1);  expect_now("down_borrow", 8'd249, 24'd72, 16'd2, 1, 1, 1);

    preload = 1'b1; pl_data = 8'd250;
    tick(1);  expect_now("preload250",  8'd250, 24'd72, 16'd2, 1, 1, 1);
    preload = 1'b0; up_dn = 1'b1; delta = 4'd5;
    tick(1);  expect_now("up_255_nowrap", 8'd255, 24'd72, 16'd2, 1, 1, 1);
    delta = 4'd1;
    tick(1);  expect_now("up_carry",    8'd0,   24'd73, 16'd2, 1, 1, 1);

    preload = 1'b1; pl_data = 8'hFF;
    tick(1);  expect_now("preloadFF",   8'hFF,  24'd73, 16'd2, 1, 1, 1);
    preload = 1'b0; delta = 4'd0;
    tick(65540); expect_now("long_hold", 8'hFF, 24'd73, 16'd2, 1, 1, 1);
    delta = 4'd1;
    tick(1);  expect_now("period_sat",  8'd0,   24'd74, 16'hFFFF, 1, 1, 1);

    delta = 4'd9;
    tick(5);
    reset = 1'b1; preload = 1'b1; pl_data = 8'hAA;
    tick(1);  expect_now("reset_beats_preload", 8'd0, 24'd0, 16'd0, 1, 1, 1);
    reset = 1'b0; preload = 1'b0;

    tick(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
